wave_capture_arbiter: RTL and testbench

Captures the four audio voices (note 1, note 2, note 3, chord) into one shared, double-buffered wave RAM that the adjustable wave display windows read. Each voice has its own trigger/capture state machine. A round-robin arbiter serialises their writes onto the single RAM write port. A global controller flips `read_index` during display blanking once every enabled voice holds a complete 256-sample frame. It sits between the note/chord sample generators and the wave RAM, and its `read_index` drives every display window.

---
 rtl/wave_pkg.sv | 26 ++
 rtl/wave_voice_capture.sv | 81 ++++++++
 rtl/wave_capture_arbiter.sv | 76 +++++++
 tb/tb_wave_capture_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types, sizes and sample conversion for the wave capture block.
package wave_pkg;
  localparam int SAMPLES_PER_WAVE = 256;
  localparam int WAVE_INDEX_W     = 8;
  localparam int VOICE_W          = 2;
  localparam int NUM_VOICES       = 4;
  localparam int SAMPLE_W         = 16;
  localparam int DISP_W           = 8;
  localparam int WR_ADDR_W        = VOICE_W + 1 + WAVE_INDEX_W;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } voice_state_e;

  typedef struct packed {
    logic [WAVE_INDEX_W-1:0] index;
    logic [DISP_W-1:0]       data;
  } wave_entry_t;

  // Signed 16-bit to unsigned 8-bit, midscale 128.
  function automatic logic [DISP_W-1:0] to_display(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: DISP_W-1]};
  endfunction
endpackage

// File: rtl/wave_voice_capture.sv
// One voice: ARMED/CAPTURE/DONE capture FSM, index counter and 1-entry holding register.
// WAVE_CAPTURE_TRIGGER_EN selects rising-zero-crossing trigger; otherwise free-running.
module wave_voice_capture
  import wave_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                enable,
  input  logic                grant,
  input  logic                flip,
  output logic                pending,
  output logic                done,
  output wave_entry_t         entry,
  output logic                ovf_pulse
);
  voice_state_e            state, state_nx;
  logic [WAVE_INDEX_W-1:0] idx, idx_nx;
  logic                    pend_nx;
  wave_entry_t             entry_nx;
  logic                    trig, state_ok, hold_free;
`ifdef WAVE_CAPTURE_TRIGGER_EN
  logic                    prev_neg, prev_nx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARMED;
      idx      <= '0;
      pending  <= 1'b0;
      entry    <= '0;
`ifdef WAVE_CAPTURE_TRIGGER_EN
      prev_neg <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      pending  <= pend_nx;
      entry    <= entry_nx;
`ifdef WAVE_CAPTURE_TRIGGER_EN
      prev_neg <= prev_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    pend_nx   = pending & ~grant;
    entry_nx  = entry;
    ovf_pulse = 1'b0;
`ifdef WAVE_CAPTURE_TRIGGER_EN
    prev_nx = prev_neg;
    trig    = prev_neg & ~sample[SAMPLE_W-1];
    if (enable && sample_valid && state == ARMED) prev_nx = sample[SAMPLE_W-1];
`else
    trig = 1'b1;
`endif
    state_ok  = (state == CAPTURE) || (state == ARMED && trig);
    // A slot being granted this cycle can take the new sample.
    hold_free = ~pending | grant;
    if (enable && sample_valid && state_ok) begin
      if (hold_free) begin
        pend_nx  = 1'b1;
        entry_nx = '{index: idx, data: to_display(sample)};
        idx_nx   = idx + 1'b1;
        state_nx = (idx == WAVE_INDEX_W'(SAMPLES_PER_WAVE-1)) ? DONE : CAPTURE;
      end else begin
        ovf_pulse = 1'b1;
      end
    end
    // Abort leaves any pending entry to drain through the arbiter.
    if (!enable || flip) begin
      state_nx = ARMED;
      idx_nx   = '0;
    end
  end

  assign done = (state == DONE);
endmodule

// File: rtl/wave_capture_arbiter.sv
// Four-voice wave capture: round-robin write arbiter, double-buffer flip, sticky overflow.
// Build option WAVE_CAPTURE_TRIGGER_EN enables zero-crossing triggering in each voice.
module wave_capture_arbiter
  import wave_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_VOICES-1:0]          sample_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] sample_in,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic                           display_idle,
  output logic                           wr_en,
  output logic [WR_ADDR_W-1:0]           wr_address,
  output logic [DISP_W-1:0]              wr_data,
  output logic                           read_index,
  output logic                           overflow
);
  logic [NUM_VOICES-1:0]   pend, done, ovf, gnt;
  wave_entry_t [NUM_VOICES-1:0] entries;
  logic [VOICE_W-1:0]      rr_ptr, gnt_id, cand;
  logic                    gnt_vld, flip;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    wave_voice_capture u_voice (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid[v]),
      .sample       (sample_in[v*SAMPLE_W +: SAMPLE_W]),
      .enable       (voice_en[v]),
      .grant        (gnt[v]),
      .flip         (flip),
      .pending      (pend[v]),
      .done         (done[v]),
      .entry        (entries[v]),
      .ovf_pulse    (ovf[v])
    );
  end

  // rr_ptr names the voice with highest priority this cycle.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      cand = rr_ptr + VOICE_W'(k);
      if (!gnt_vld && pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

  assign flip = (&(done | ~voice_en)) & ~(|pend) & display_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      read_index <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en    <= gnt_vld;
      overflow <= overflow | (|ovf);
      if (gnt_vld) begin
        rr_ptr     <= gnt_id + 1'b1;
        wr_address <= {gnt_id, ~read_index, entries[gnt_id].index};
        wr_data    <= entries[gnt_id].data;
      end
      if (flip) read_index <= ~read_index;
    end
  end
endmodule

// File: tb/tb_wave_capture_arbiter.sv
// Randomised bench for wave_capture_arbiter against a cycle-level behavioural model.
module tb_wave_capture_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sample_valid, voice_en;
  logic [63:0] sample_in;
  logic        display_idle;
  logic        wr_en, read_index, overflow;
  logic [10:0] wr_address;
  logic [7:0]  wr_data;

`ifdef WAVE_CAPTURE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  wave_capture_arbiter dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .voice_en(voice_en), .display_idle(display_idle), .wr_en(wr_en),
    .wr_address(wr_address), .wr_data(wr_data), .read_index(read_index), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=waiting for start, 1=capturing, 2=frame full
  int mmode[4], mcnt[4], mpidx[4], mpdat[4], mlast;
  bit mprev[4], mpend[4], mri, movf, xen;
  int xaddr, xdata;

  function automatic int disp(input int s);
    return (s + 32768) / 256;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      mmode[v] = 0; mcnt[v] = 0; mprev[v] = 0; mpend[v] = 0; mpidx[v] = 0; mpdat[v] = 0;
    end
    mlast = 3; mri = 0; movf = 0; xen = 0; xaddr = 0; xdata = 0;
  endtask

  task automatic model_step();
    int g, s;
    bit all_done, any_pend, flip, ok;
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && mpend[(mlast + k) % 4]) g = (mlast + k) % 4;
    all_done = 1; any_pend = 0;
    for (int v = 0; v < 4; v++) begin
      if (voice_en[v] && mmode[v] != 2) all_done = 0;
      if (mpend[v]) any_pend = 1;
    end
    flip = all_done && !any_pend && display_idle;
    xen = (g >= 0);
    if (g >= 0) begin
      xaddr = g * 512 + (mri ? 0 : 256) + mpidx[g];
      xdata = mpdat[g];
      mlast = g;
      mpend[g] = 0;
    end
    for (int v = 0; v < 4; v++) begin
      s = int'($signed(sample_in[16*v +: 16]));
      if (voice_en[v] && sample_valid[v]) begin
        ok = (mmode[v] == 1) || (mmode[v] == 0 && (!TRIG || (mprev[v] && s >= 0)));
        if (TRIG && mmode[v] == 0) mprev[v] = (s < 0);
        if (ok) begin
          if (!mpend[v]) begin
            mpend[v] = 1; mpidx[v] = mcnt[v]; mpdat[v] = disp(s);
            mmode[v] = (mcnt[v] == 255) ? 2 : 1;
            mcnt[v]++;
          end else movf = 1;
        end
      end
      if (!voice_en[v] || flip) begin mmode[v] = 0; mcnt[v] = 0; end
    end
    if (flip) mri = ~mri;
  endtask

  task automatic cyc(input logic [3:0] sv, input logic [63:0] smp, input logic [3:0] en,
                     input logic idle);
    sample_valid = sv; sample_in = smp; voice_en = en; display_idle = idle;
    model_step();
    @(posedge clk); #1;
    chk("wr_en", {31'b0, wr_en}, {31'b0, xen});
    if (xen) begin
      chk("wr_address", {21'b0, wr_address}, xaddr);
      chk("wr_data", {24'b0, wr_data}, xdata);
    end
    chk("read_index", {31'b0, read_index}, {31'b0, mri});
    chk("overflow", {31'b0, overflow}, {31'b0, movf});
    sample_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = '0; model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [63:0] lane(input int v, input int s);
    logic [63:0] r;
    r = '0;
    r[16*v +: 16] = 16'(s);
    return r;
  endfunction

  function automatic logic [63:0] all4(input int s);
    logic [15:0] x;
    x = 16'(s);
    return {4{x}};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int guard;
    logic [3:0] sv, en;
    reset = 1'b1; sample_valid = '0; sample_in = '0; voice_en = '0; display_idle = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_wr_address", {21'b0, wr_address}, 0);
    chk("rst_wr_data", {24'b0, wr_data}, 0);
    chk("rst_read_index", {31'b0, read_index}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    reset = 1'b0;

    // Trigger sequence on voice 0
    cyc(4'b0001, lane(0, -100), 4'hF, 0); cyc(0, '0, 4'hF, 0);
    cyc(4'b0001, lane(0, -5), 4'hF, 0);   cyc(0, '0, 4'hF, 0);
    cyc(4'b0001, lane(0, 3), 4'hF, 0);
    repeat (3) cyc(0, '0, 4'hF, 0);

    // Simultaneous arrivals: serialised in voice order
    do_reset();
    cyc(4'hF, all4(-1000), 4'hF, 0); repeat (5) cyc(0, '0, 4'hF, 0);
    cyc(4'hF, all4(1000), 4'hF, 0);  repeat (5) cyc(0, '0, 4'hF, 0);
    cyc(4'hF, rnd64(), 4'hF, 0);     repeat (5) cyc(0, '0, 4'hF, 0);

    // Holding-register overflow on voice 2
    do_reset();
    cyc(4'b0111, all4(-200), 4'hF, 0); repeat (5) cyc(0, '0, 4'hF, 0);
    if (TRIG) begin
      cyc(4'b0011, all4(200), 4'hF, 0); repeat (5) cyc(0, '0, 4'hF, 0);
    end
    cyc(4'b0011, all4(300), 4'hF, 0);
    cyc(4'b0100, all4(400), 4'hF, 0);
    cyc(4'b0100, all4(500), 4'hF, 0);
    repeat (5) cyc(0, '0, 4'hF, 0);
    cyc(4'b0100, all4(600), 4'hF, 0);
    repeat (5) cyc(0, '0, 4'hF, 0);

    // Staggered low-rate capture with flips
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      sv = '0;
      sv[t % 4] = ($urandom_range(0, 3) != 0);
      cyc(sv, rnd64(), 4'hF, ($urandom_range(0, 7) == 0));
    end

    // Reset while voice 0 is mid-frame
    guard = 0;
    while (!(mmode[0] == 1 && mcnt[0] >= 100) && guard < 3000) begin
      cyc((guard % 2 == 0) ? 4'b0001 : 4'b0000, rnd64(), 4'hF, 0);
      guard++;
    end
    if (guard >= 3000) chk("midframe_timeout", 0, 1);
    reset = 1'b1; #1;
    chk("async_rst_wr_en", {31'b0, wr_en}, 0);
    chk("async_rst_read_index", {31'b0, read_index}, 0);
    model_reset(); sample_valid = '0;
    @(posedge clk); #1; reset = 1'b0;
    cyc(4'b0001, lane(0, -7), 4'hF, 0); cyc(0, '0, 4'hF, 0);
    cyc(4'b0001, lane(0, 9), 4'hF, 0);
    repeat (3) cyc(0, '0, 4'hF, 0);

    // Only voice 0 enabled: flip without writes from 1..3
    do_reset();
    guard = 0;
    while (!(mmode[0] == 2 && !mpend[0]) && guard < 3000) begin
      sv = {$urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 1) == 0, guard % 2 == 0};
      cyc(sv, rnd64(), 4'b0001, 0);
      guard++;
    end
    if (guard >= 3000) chk("disabled_done_timeout", 0, 1);
    cyc(0, '0, 4'b0001, 1);
    chk("disabled_flip", {31'b0, read_index}, 1);
    repeat (3) cyc(0, '0, 4'b0001, 0);

    // High-rate random with enable changes and overflow
    do_reset();
    en = 4'hF;
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      cyc(4'($urandom), rnd64(), en, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
